// File: rtl/uart_pkg.sv
// Shared definitions for the uart_tx arbiter and the uart_tx it drives.
//  - arb_state_e : arbiter sequencing states
//  - PARITY_* / BAUD_* : line configuration codes understood by uart_tx
//  - clog2       : width helper, never returns less than 1
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARB   = 3'd1,
      START = 3'd2,
      BUSY  = 3'd3,
      GAP   = 3'd4
   } arb_state_e;

   localparam logic [1:0] PARITY_NONE = 2'b00;
   localparam logic [1:0] PARITY_ODD  = 2'b01;
   localparam logic [1:0] PARITY_EVEN = 2'b10;

   localparam logic [1:0] BAUD_2400   = 2'b00;
   localparam logic [1:0] BAUD_4800   = 2'b01;
   localparam logic [1:0] BAUD_9600   = 2'b10;
   localparam logic [1:0] BAUD_19200  = 2'b11;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return (res < 1) ? 1 : res;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//  req        : request vector, one bit per requester
//  last_grant : index granted most recently; scanning starts one above it
//  grant      : first requesting index found, wrapping modulo N_REQ
//  hit        : 1 when any request was found (grant is last_grant otherwise)
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int GW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [GW-1:0]    last_grant,
   output logic [GW-1:0]    grant,
   output logic             hit
);

   logic [GW:0]   sum;
   logic [GW-1:0] idx;

   always_comb begin
      grant = last_grant;
      hit   = 1'b0;
      sum   = '0;
      idx   = '0;
      // Offset N_REQ brings the scan back to last_grant itself, so a lone
      // requester that was served last can still be served again.
      for (int off = 1; off <= N_REQ; off++) begin
         sum = {1'b0, last_grant} + (GW+1)'(off);
         if (sum >= (GW+1)'(N_REQ)) begin
            sum = sum - (GW+1)'(N_REQ);
         end
         idx = sum[GW-1:0];
         if (!hit && req[idx]) begin
            hit   = 1'b1;
            grant = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among N_REQ byte requesters.
// Sequences uart_tx send/active, holds data and line config for a whole frame,
// and only takes new config while idle.
//  clk, rst_n          : system clock, async active-low reset
//  req_valid/req_data  : per-requester byte pending, byte i at [8*i+7:8*i]
//  req_ready           : 1-cycle pulse when requester i's byte is taken
//  cfg_parity_type/cfg_baud_rate : line config, sampled in IDLE only
//  uart_send/uart_data/uart_parity_type/uart_baud_rate : to uart_tx
//  uart_active         : from uart_tx, baud-clock domain (synchronised here)
//  busy, grant_id, timeout_err : status
//
// state | meaning
// IDLE  | track cfg, wait for any req_valid
// ARB   | pick requester, load data, pulse req_ready
// START | hold send high until uart_tx reports active or timer expires
// BUSY  | frame in flight, wait for active to fall
// GAP   | GAP_CYCLES idle cycles so uart_tx sees send low on a baud edge
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int START_TIMEOUT = 65535,
   parameter int GAP_CYCLES    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [8*N_REQ-1:0]        req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [1:0]                cfg_parity_type,
   input  logic [1:0]                cfg_baud_rate,
   output logic                      uart_send,
   output logic [7:0]                uart_data,
   output logic [1:0]                uart_parity_type,
   output logic [1:0]                uart_baud_rate,
   input  logic                      uart_active,
   output logic                      busy,
   output logic [clog2(N_REQ)-1:0]   grant_id,
   output logic                      timeout_err
);

   localparam int GW  = clog2(N_REQ);
   localparam int TW  = clog2(START_TIMEOUT + 1);
   localparam int GPW = clog2(GAP_CYCLES + 1);

   arb_state_e       state_q, state_d;
   logic             act_meta_q, act_s_q;
   logic [TW-1:0]    timer_q, timer_d;
   logic [GPW-1:0]   gap_q, gap_d;
   logic [GW-1:0]    last_grant_q, last_grant_d;
   logic [GW-1:0]    grant_q, grant_d;
   logic [N_REQ-1:0] ready_q, ready_d;
   logic             send_q, send_d;
   logic [7:0]       data_q, data_d;
   logic [1:0]       parity_q, parity_d;
   logic [1:0]       baud_q, baud_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;

   logic [GW-1:0]    pick_idx;
   logic             pick_hit;
   logic [7:0]       pick_data;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .GW    (GW)
   ) u_rr (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .grant      (pick_idx),
      .hit        (pick_hit)
   );

   always_comb begin
      pick_data = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx == GW'(i)) begin
            pick_data = req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      gap_d        = gap_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      ready_d      = '0;
      send_d       = send_q;
      data_d       = data_q;
      parity_d     = parity_q;
      baud_d       = baud_q;
      timeout_d    = 1'b0;

      case (state_q)
         IDLE: begin
            parity_d = cfg_parity_type;
            baud_d   = cfg_baud_rate;
            if (|req_valid) begin
               state_d = ARB;
            end
         end
         ARB: begin
            // A requester may withdraw between IDLE and ARB; then nothing is acked.
            if (pick_hit) begin
               data_d       = pick_data;
               grant_d      = pick_idx;
               last_grant_d = pick_idx;
               for (int i = 0; i < N_REQ; i++) begin
                  ready_d[i] = (pick_idx == GW'(i));
               end
               send_d  = 1'b1;
               timer_d = '0;
               state_d = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            // A stale active still counts as a start; BUSY then waits for its fall.
            if (act_s_q) begin
               send_d  = 1'b0;
               state_d = BUSY;
            end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
               send_d    = 1'b0;
               timeout_d = 1'b1;
               gap_d     = GPW'(GAP_CYCLES - 1);
               state_d   = GAP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         BUSY: begin
            if (!act_s_q) begin
               gap_d   = GPW'(GAP_CYCLES - 1);
               state_d = GAP;
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: begin
            send_d  = 1'b0;
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         act_meta_q   <= 1'b0;
         act_s_q      <= 1'b0;
         timer_q      <= '0;
         gap_q        <= '0;
         last_grant_q <= GW'(N_REQ - 1);
         grant_q      <= '0;
         ready_q      <= '0;
         send_q       <= 1'b0;
         data_q       <= 8'h00;
         parity_q     <= 2'b00;
         baud_q       <= 2'b00;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         act_meta_q   <= uart_active;
         act_s_q      <= act_meta_q;
         timer_q      <= timer_d;
         gap_q        <= gap_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         ready_q      <= ready_d;
         send_q       <= send_d;
         data_q       <= data_d;
         parity_q     <= parity_d;
         baud_q       <= baud_d;
         busy_q       <= busy_d;
         timeout_q    <= timeout_d;
      end
   end

   assign req_ready        = ready_q;
   assign uart_send        = send_q;
   assign uart_data        = data_q;
   assign uart_parity_type = parity_q;
   assign uart_baud_rate   = baud_q;
   assign busy             = busy_q;
   assign grant_id         = grant_q;
   assign timeout_err      = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx active model, requesters that
// drop valid after their last ack, and grant/data scoreboards filled from a
// round-robin model when requests are launched.
module tb_uart_tx_arbiter;

   localparam int N         = 4;
   localparam int TO        = 16;
   localparam int GAPC      = 2;
   localparam int FRAME_LEN = 20;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    req_valid;
   logic [31:0]   req_data;
   logic [3:0]    req_ready;
   logic [1:0]    cfg_parity_type;
   logic [1:0]    cfg_baud_rate;
   logic          uart_send;
   logic [7:0]    uart_data;
   logic [1:0]    uart_parity_type;
   logic [1:0]    uart_baud_rate;
   logic          uart_active;
   logic          busy;
   logic [1:0]    grant_id;
   logic          timeout_err;

   int            n_checks = 0;
   int            n_errors = 0;
   int            rq_cnt[4];
   logic [7:0]    rq_byte[4];
   int            exp_grant[$];
   logic [7:0]    exp_data[$];
   int            m_dly, m_len, m_last;
   logic [7:0]    m_byte;
   bit            model_en;
   logic          send_prev;
   int            n_send_hi, n_to;
   int            s0, t0, g, n;

   uart_tx_arbiter #(
      .N_REQ         (N),
      .START_TIMEOUT (TO),
      .GAP_CYCLES    (GAPC)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .cfg_parity_type  (cfg_parity_type),
      .cfg_baud_rate    (cfg_baud_rate),
      .uart_send        (uart_send),
      .uart_data        (uart_data),
      .uart_parity_type (uart_parity_type),
      .uart_baud_rate   (uart_baud_rate),
      .uart_active      (uart_active),
      .busy             (busy),
      .grant_id         (grant_id),
      .timeout_err      (timeout_err)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_next(input logic [3:0] mask, input int last);
      for (int off = 1; off <= N; off++) begin
         if (mask[(last + off) % N]) return (last + off) % N;
      end
      return last;
   endfunction

   // One cycle: sample at negedge, run uart_tx model, serve requester acks.
   task automatic tick();
      int gi;
      @(negedge clk);
      if (uart_send) n_send_hi++;
      if (timeout_err) n_to++;
      if (m_dly > 0) begin
         m_dly--;
         if (m_dly == 0) begin
            uart_active = 1'b1;
            m_len = FRAME_LEN;
            if (exp_data.size() == 0) begin
               m_byte = 8'h00;
               check("frame_unexpected", 1, 0);
            end else begin
               m_byte = exp_data.pop_front();
               check("frame_data", uart_data, m_byte);
            end
         end
      end else if (m_len > 0) begin
         m_len--;
         if (m_len == 0) begin
            check("data_hold", uart_data, m_byte);
            uart_active = 1'b0;
         end
      end else if (model_en && uart_send && !send_prev) begin
         m_dly = 3;
      end
      send_prev = uart_send;
      if (req_ready != 4'b0000) begin
         if (exp_grant.size() == 0) begin
            check("ready_unexpected", req_ready, 0);
         end else begin
            gi = exp_grant.pop_front();
            check("ready_vec", req_ready, 1 << gi);
            check("grant_id", grant_id, gi);
         end
         for (int i = 0; i < N; i++) begin
            if (req_ready[i] && rq_cnt[i] > 0) begin
               rq_cnt[i]--;
               if (rq_cnt[i] == 0) req_valid[i] = 1'b0;
            end
         end
      end
   endtask

   task automatic launch(input int c0, input int c1, input int c2, input int c3);
      int c[4];
      logic [3:0] mask;
      int gg;
      c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
      mask = 4'b0000;
      for (int i = 0; i < N; i++) begin
         rq_cnt[i] = c[i];
         req_data[8*i +: 8] = rq_byte[i];
         if (c[i] > 0) mask[i] = 1'b1;
      end
      while (mask != 4'b0000) begin
         gg = rr_next(mask, m_last);
         exp_grant.push_back(gg);
         if (model_en) exp_data.push_back(rq_byte[gg]);
         c[gg]--;
         if (c[gg] == 0) mask[gg] = 1'b0;
         m_last = gg;
      end
      for (int i = 0; i < N; i++) begin
         if (rq_cnt[i] > 0) req_valid[i] = 1'b1;
      end
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while ((busy || req_valid != 4'b0000 || m_dly != 0 || m_len != 0) && k < 2000);
      check({tag, "_done"}, (k < 2000) ? 1 : 0, 1);
      check({tag, "_drained"}, exp_grant.size() + exp_data.size(), 0);
   endtask

   task automatic clear_model();
      uart_active = 1'b0;
      m_dly = 0;
      m_len = 0;
      send_prev = 1'b0;
      exp_grant.delete();
      exp_data.delete();
      req_valid = 4'b0000;
      for (int i = 0; i < N; i++) rq_cnt[i] = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_model();
      tick();
      tick();
      rst_n = 1'b1;
      m_last = N - 1;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = 4'b0000;
      req_data = '0;
      cfg_parity_type = 2'b00;
      cfg_baud_rate = 2'b00;
      uart_active = 1'b0;
      model_en = 1'b1;
      n_send_hi = 0;
      n_to = 0;
      clear_model();
      rq_byte[0] = 8'hA5; rq_byte[1] = 8'h11; rq_byte[2] = 8'h12; rq_byte[3] = 8'h13;
      do_reset();

      check("rst_send", uart_send, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", req_ready, 0);
      check("rst_grant", grant_id, 0);
      check("rst_data", uart_data, 0);
      check("rst_timeout", timeout_err, 0);

      // single request, 2-cycle latency to send
      launch(1, 0, 0, 0);
      tick();
      check("lat_send_early", uart_send, 0);
      tick();
      check("lat_send", uart_send, 1);
      check("lat_busy", busy, 1);
      wait_idle("single");

      // all four continuously valid from a fresh reset: 10,11,12,13,10
      do_reset();
      rq_byte[0] = 8'h10;
      launch(2, 1, 1, 1);
      wait_idle("all4");

      // last grant becomes 2, then 0101 wraps to 0 before 2
      launch(0, 0, 1, 0);
      wait_idle("to2");
      check("wrap_last", grant_id, 2);
      launch(1, 0, 1, 0);
      wait_idle("wrap");
      check("wrap_final", grant_id, 2);

      // cfg only taken between frames
      cfg_baud_rate = 2'b01;
      cfg_parity_type = 2'b10;
      tick();
      tick();
      check("cfg_idle_baud", uart_baud_rate, 2'b01);
      check("cfg_idle_par", uart_parity_type, 2'b10);
      launch(0, 0, 0, 1);
      n = 0;
      while (!uart_active && n < 200) begin tick(); n++; end
      check("cfg_active_seen", uart_active, 1);
      cfg_baud_rate = 2'b11;
      cfg_parity_type = 2'b01;
      tick(); tick(); tick();
      check("cfg_frame_baud", uart_baud_rate, 2'b01);
      check("cfg_frame_par", uart_parity_type, 2'b10);
      wait_idle("cfg");
      tick();
      check("cfg_after_baud", uart_baud_rate, 2'b11);
      check("cfg_after_par", uart_parity_type, 2'b01);

      // start timeout with active tied low
      model_en = 1'b0;
      s0 = n_send_hi;
      t0 = n_to;
      launch(0, 1, 0, 0);
      wait_idle("timeout");
      check("to_send_cycles", n_send_hi - s0, TO);
      check("to_pulses", n_to - t0, 1);
      model_en = 1'b1;
      launch(0, 0, 1, 0);
      wait_idle("after_to");

      // reset during BUSY
      launch(0, 1, 0, 0);
      n = 0;
      while (!uart_active && n < 200) begin tick(); n++; end
      tick(); tick(); tick(); tick();
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_send", uart_send, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", req_ready, 0);
      check("mid_rst_grant", grant_id, 0);
      clear_model();
      tick();
      tick();
      rst_n = 1'b1;
      m_last = N - 1;
      tick();
      launch(1, 1, 0, 0);
      wait_idle("post_rst");
      check("post_rst_grant", grant_id, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
